rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single line-read ROM port (rom_addr/rom_re in, line data/rom_oe out) between two requesters: port 0 (instruction fetch / I-cache fill) and port 1 (data-side or loader line reads).
- Sits between the core-side requesters and the rom instance inside the top wrapper.
- Serialises requests with round-robin arbitration, sequences exactly one ROM transaction at a time, and returns the line or a timeout error to the granted requester.

Parameters:
- WORD_ADR_SIZE, `CACHE_WORD_ADR_SIZE: log2 of words per line.
- WORDS, 2**WORD_ADR_SIZE: words per line (derived, not overridden).
- TIMEOUT, 64: max cycles waiting for rom_oe before error; legal range 2..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 request, level; held until resp0_valid
- addr0  in  32  port 0 byte address; stable while req0=1
- req1  in  1  port 1 request
- addr1  in  32  port 1 byte address
- resp0_valid  out  1  one-cycle response strobe, port 0
- resp1_valid  out  1  one-cycle response strobe, port 1
- resp_data  out  32*WORDS  line data, word i at bits [32i+31:32i]; shared by both ports
- resp_err  out  1  qualifies respN_valid; 1 = timeout, resp_data all zero
- busy  out  1  1 in any state other than IDLE
- rom_addr  out  32  line-aligned address to ROM
- rom_re  out  1  ROM read strobe
- rom_data  in  32*WORDS  ROM line output
- rom_oe  in  1  ROM output valid

Behaviour:
- All outputs registered. Reset values: respN_valid=0, resp_err=0, resp_data=0, busy=0, rom_re=0, rom_addr=0; FSM=IDLE; last_gnt=1, so port 0 wins first; timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, no req: stay.
- IDLE, any req: grant the requesting port. When both request, grant the port != last_gnt. Latch the granted addr with the low (WORD_ADR_SIZE+2) bits forced to zero, record the grant, update last_gnt, go to ISSUE.
- ISSUE: rom_re=1 for exactly this one cycle, rom_addr=latched addr. Clear the counter. Go to WAIT.
- WAIT: rom_re=0, rom_addr held.
  - rom_oe=1: capture rom_data into resp_data, err=0, go to RESP.
  - Otherwise the counter increments. When counter reaches TIMEOUT-1 without rom_oe: resp_data=0, err=1, go to RESP.
- rom_oe in the ISSUE cycle is ignored. rom_oe is only sampled in WAIT.
- RESP: resp<gnt>_valid=1 and resp_err valid for this one cycle. resp_data holds until the next capture. Go to IDLE.
- Latency: req high in IDLE at cycle T → rom_re at T+1 → resp_valid one cycle after the cycle rom_oe is sampled. With a single-cycle ROM (oe at T+2), resp_valid is at T+3.
- Requester drops req the cycle after respN_valid. A req still high in the IDLE cycle after RESP is treated as a new request.
- A req withdrawn before grant is ignored. A req withdrawn after grant does not abort; the response is still delivered.
- rom_oe in IDLE/RESP (stale or late after timeout) is ignored and causes no response.
- addr is sampled only at grant. Later changes have no effect on the transaction in flight.
- Reset in any state → IDLE next cycle, all outputs at reset values. No response is issued for the aborted transaction.
- Counter is 8 bits; it cannot wrap because TIMEOUT ≤ 255.

Decomposition:
- Shared package rv32i gets:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} rom_arb_state_t
  - localparam ROM_LINE_W = 32*2**`CACHE_WORD_ADR_SIZE
- One natural sub-module: rr_arbiter2 (2-input round-robin grant with last_gnt register, update-enable input).
- The FSM and datapath stay in rom_arbiter.

Test Plan:
- Single request: req0=1, addr0=0x0000_0104, WORD_ADR_SIZE=2, ROM oe 1 cycle after re → rom_re single pulse with rom_addr=0x0000_0100; resp0_valid exactly 3 cycles after req0; resp_data equals ROM line; resp_err=0; resp1_valid never asserted.
- Contention: req0 and req1 asserted together and held across 4 transactions → grants alternate 0,1,0,1; each port gets exactly one resp per request; rom_re never asserted while busy in WAIT.
- Timeout: TIMEOUT=8, ROM never asserts oe → resp1_valid with resp_err=1 and resp_data=0 eight cycles after entering WAIT; a rom_oe injected 2 cycles later produces no response.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT → next cycle busy=0, all outputs 0; the following rom_oe produces no response; a new req0 afterwards is served normally with port 0 first.
- Addr change after grant: addr0 changed from 0x40 to 0x80 in the ISSUE cycle → rom_addr stays 0x40; returned line is line 0x40.
- Back-to-back: req0 held high through resp0_valid → second rom_re exactly 2 cycles after the first resp0_valid (RESP→IDLE→ISSUE).

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions used by the memory-side blocks:
// line geometry, ROM arbiter state encoding and a line-alignment helper.
`ifndef CACHE_WORD_ADR_SIZE
`define CACHE_WORD_ADR_SIZE 2
`endif

package rv32i;

  localparam int ROM_LINE_W = 32 * 2**`CACHE_WORD_ADR_SIZE;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } rom_arb_state_t;

  function automatic logic [31:0] line_base(
    logic [31:0] a,
    int unsigned off
  );
    return a & ~((32'd1 << off) - 32'd1);
  endfunction

endpackage

// File: rtl/rom_arbiter_rr.sv
// Two-input round-robin grant; the port that did not win last time
// wins a tie. last_gnt advances only when the caller accepts the grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt,
  output logic       any
);

  logic last_gnt;

  assign any = |req;
  assign gnt = (&req) ? ~last_gnt : req[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (update) begin
      last_gnt <= gnt;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single line-read ROM port between two requesters:
// one transaction at a time, round-robin, with an oe timeout.
module rom_arbiter
  import rv32i::*;
#(
  parameter int WORD_ADR_SIZE = `CACHE_WORD_ADR_SIZE,
  parameter int TIMEOUT       = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req0,
  input  logic [31:0]                   addr0,
  input  logic                          req1,
  input  logic [31:0]                   addr1,
  output logic                          resp0_valid,
  output logic                          resp1_valid,
  output logic [32*(2**WORD_ADR_SIZE)-1:0] resp_data,
  output logic                          resp_err,
  output logic                          busy,
  output logic [31:0]                   rom_addr,
  output logic                          rom_re,
  input  logic [32*(2**WORD_ADR_SIZE)-1:0] rom_data,
  input  logic                          rom_oe
);

  localparam int WORDS = 2**WORD_ADR_SIZE;
  localparam int LW    = 32 * WORDS;
  localparam int OFF   = WORD_ADR_SIZE + 2;
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  rom_arb_state_t state, state_n;

  logic [7:0]    cnt, cnt_n;
  logic          sel, sel_n;
  logic          gnt, any, upd;
  logic [31:0]   addr_n;
  logic [LW-1:0] data_n;
  logic          err_n, re_n, v0_n, v1_n;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .update (upd),
    .gnt    (gnt),
    .any    (any)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    addr_n  = rom_addr;
    data_n  = resp_data;
    err_n   = resp_err;
    upd     = 1'b0;
    re_n    = 1'b0;
    v0_n    = 1'b0;
    v1_n    = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (any) begin
          upd     = 1'b1;
          sel_n   = gnt;
          addr_n  = line_base(gnt ? addr1 : addr0,
                              int'(OFF));
          re_n    = 1'b1;
          state_n = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_n   = 8'd0;
        state_n = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (rom_oe) begin
          data_n  = rom_data;
          err_n   = 1'b0;
          v0_n    = ~sel;
          v1_n    = sel;
          state_n = ARB_RESP;
        end else if (cnt == TLAST) begin
          data_n  = '0;
          err_n   = 1'b1;
          v0_n    = ~sel;
          v1_n    = sel;
          state_n = ARB_RESP;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ARB_RESP: begin
        state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up
  // with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      cnt         <= 8'd0;
      sel         <= 1'b0;
      rom_addr    <= '0;
      rom_re      <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sel         <= sel_n;
      rom_addr    <= addr_n;
      rom_re      <= re_n;
      resp_data   <= data_n;
      resp_err    <= err_n;
      resp0_valid <= v0_n;
      resp1_valid <= v1_n;
      busy        <= (state_n != ARB_IDLE);
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: single-cycle ROM model, contention,
// timeout, reset mid-transaction, late addr change and back-to-back.
module tb_rom_arbiter;

  localparam int LW = 128;

  logic          clk;
  logic          reset;
  logic          req0, req1;
  logic [31:0]   addr0, addr1;
  logic          resp0_valid, resp1_valid;
  logic [LW-1:0] resp_data;
  logic          resp_err, busy;
  logic [31:0]   rom_addr;
  logic          rom_re;
  logic [LW-1:0] rom_data;
  logic          rom_oe;

  logic rom_oe_m, inj_oe, rom_en;
  int   tests, fails;
  int   n0, n1, nre;

  assign rom_oe = rom_oe_m | inj_oe;

  rom_arbiter #(
    .WORD_ADR_SIZE (2),
    .TIMEOUT       (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .addr0       (addr0),
    .req1        (req1),
    .addr1       (addr1),
    .resp0_valid (resp0_valid),
    .resp1_valid (resp1_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .busy        (busy),
    .rom_addr    (rom_addr),
    .rom_re      (rom_re),
    .rom_data    (rom_data),
    .rom_oe      (rom_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] line_of(logic [31:0] a);
    logic [LW-1:0] l;
    for (int i = 0; i < 4; i++)
      l[32*i +: 32] = (a + 32'(4*i)) ^ 32'hC0DE_0000;
    return l;
  endfunction

  // Synchronous ROM: oe and data one cycle after re.
  always @(posedge clk) begin
    rom_oe_m <= rom_en && rom_re;
    if (rom_re) rom_data <= line_of(rom_addr);
  end

  always @(posedge clk) begin
    if (resp0_valid) n0 <= n0 + 1;
    if (resp1_valid) n1 <= n1 + 1;
    if (rom_re)      nre <= nre + 1;
  end

  task automatic chk(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int b0, b1, bre;
    tests = 0; fails = 0;
    n0 = 0; n1 = 0; nre = 0;
    reset = 1'b1; req0 = 0; req1 = 0;
    addr0 = '0; addr1 = '0;
    inj_oe = 0; rom_en = 1;
    rom_oe_m = 0; rom_data = '0;
    step(2);
    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_re", LW'(rom_re), LW'(0));
    chk("rst_addr", LW'(rom_addr), LW'(0));
    chk("rst_data", resp_data, '0);
    chk("rst_valid", LW'({resp0_valid, resp1_valid, resp_err}), LW'(0));
    reset = 1'b0;
    step(1);

    // single request, 1-cycle ROM
    req0 = 1; addr0 = 32'h0000_0104;
    step(1);
    chk("t1_re", LW'(rom_re), LW'(1));
    chk("t1_addr", LW'(rom_addr), LW'(32'h100));
    chk("t1_busy", LW'(busy), LW'(1));
    step(1);
    chk("t1_re_off", LW'(rom_re), LW'(0));
    chk("t1_early", LW'(resp0_valid), LW'(0));
    step(1);
    chk("t1_v0", LW'(resp0_valid), LW'(1));
    chk("t1_data", resp_data, line_of(32'h100));
    chk("t1_err", LW'(resp_err), LW'(0));
    req0 = 0;
    step(3);
    chk("t1_n1", LW'(n1), LW'(0));
    chk("t1_nre", LW'(nre), LW'(1));
    chk("t1_idle", LW'(busy), LW'(0));

    // contention, both held across 4 transactions
    do_reset();
    b0 = n0; b1 = n1; bre = nre;
    addr0 = 32'h200; addr1 = 32'h314;
    req0 = 1; req1 = 1;
    step(3);
    chk("c1_port", LW'({resp0_valid, resp1_valid}), LW'(2'b10));
    chk("c1_data", resp_data, line_of(32'h200));
    step(4);
    chk("c2_port", LW'({resp0_valid, resp1_valid}), LW'(2'b01));
    chk("c2_data", resp_data, line_of(32'h310));
    step(4);
    chk("c3_port", LW'({resp0_valid, resp1_valid}), LW'(2'b10));
    step(4);
    chk("c4_port", LW'({resp0_valid, resp1_valid}), LW'(2'b01));
    req0 = 0; req1 = 0;
    step(3);
    chk("c_n0", LW'(n0 - b0), LW'(2));
    chk("c_n1", LW'(n1 - b1), LW'(2));
    chk("c_nre", LW'(nre - bre), LW'(4));

    // timeout on port 1, then a late oe
    rom_en = 0;
    b1 = n1;
    req1 = 1; addr1 = 32'h7F8;
    step(1);
    chk("to_addr", LW'(rom_addr), LW'(32'h7F0));
    step(8);
    chk("to_early", LW'(resp1_valid), LW'(0));
    chk("to_busy", LW'(busy), LW'(1));
    step(1);
    chk("to_v1", LW'(resp1_valid), LW'(1));
    chk("to_err", LW'(resp_err), LW'(1));
    chk("to_data", resp_data, '0);
    req1 = 0;
    step(2);
    inj_oe = 1;
    step(1);
    inj_oe = 0;
    step(3);
    chk("to_late_n1", LW'(n1 - b1), LW'(1));
    chk("to_late_busy", LW'(busy), LW'(0));

    // reset during WAIT
    b0 = n0; b1 = n1;
    req0 = 1; addr0 = 32'h500;
    step(2);
    chk("rw_busy", LW'(busy), LW'(1));
    reset = 1; req0 = 0;
    step(1);
    chk("rw_busy0", LW'(busy), LW'(0));
    chk("rw_err0", LW'(resp_err), LW'(0));
    chk("rw_addr0", LW'(rom_addr), LW'(0));
    chk("rw_re0", LW'(rom_re), LW'(0));
    chk("rw_data0", resp_data, '0);
    reset = 0;
    inj_oe = 1;
    step(1);
    inj_oe = 0;
    step(3);
    chk("rw_noresp", LW'(n0 - b0), LW'(0));
    rom_en = 1;
    addr0 = 32'h600; addr1 = 32'h700;
    req0 = 1; req1 = 1;
    step(3);
    chk("rw_p0first", LW'({resp0_valid, resp1_valid}), LW'(2'b10));
    chk("rw_data", resp_data, line_of(32'h600));
    req0 = 0; req1 = 0;
    step(6);
    chk("rw_withdrawn", LW'(n1 - b1), LW'(0));

    // addr change in ISSUE
    req0 = 1; addr0 = 32'h40;
    step(1);
    addr0 = 32'h80;
    chk("ac_issue", LW'(rom_addr), LW'(32'h40));
    step(1);
    chk("ac_wait", LW'(rom_addr), LW'(32'h40));
    step(1);
    chk("ac_v0", LW'(resp0_valid), LW'(1));
    chk("ac_data", resp_data, line_of(32'h40));
    req0 = 0;
    step(2);

    // back-to-back with req0 held
    req0 = 1; addr0 = 32'h1000;
    step(3);
    chk("bb_v0a", LW'(resp0_valid), LW'(1));
    step(1);
    chk("bb_gap", LW'(rom_re), LW'(0));
    step(1);
    chk("bb_re2", LW'(rom_re), LW'(1));
    chk("bb_addr2", LW'(rom_addr), LW'(32'h1000));
    step(2);
    chk("bb_v0b", LW'(resp0_valid), LW'(1));
    req0 = 0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
